// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_ptr_ctrl
// Brief    : Read/write pointer controller for the synchronous FIFO. Gates
//            requests against full/empty and exports addresses, the pointer
//            difference, the wrap bits and the occupancy.
//            Optional sticky error flags are enabled by FIFO_ERR_LOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl #(
    parameter int A_LEN = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic             wr_ack,
    output logic             rd_ack,
    output logic [A_LEN-1:0] wr_addr,
    output logic [A_LEN-1:0] rd_addr,
    output logic [A_LEN-1:0] ptr_diff,
    output logic             MSB_wr_ptr,
    output logic             MSB_rd_ptr,
    output logic [A_LEN:0]   occupancy,
    output logic             ovf_err,
    output logic             udf_err
);

    localparam logic [A_LEN:0] c_PTR_ONE = {{A_LEN{1'b0}}, 1'b1};

    logic [A_LEN:0] r_wr_ptr;
    logic [A_LEN:0] r_rd_ptr;
    logic [A_LEN:0] w_occupancy;
    logic           w_empty;
    logic           w_full;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[A_LEN-1:0] == r_rd_ptr[A_LEN-1:0]) &&
                     (r_wr_ptr[A_LEN] != r_rd_ptr[A_LEN]);

    // Acks are held low while reset is asserted so nothing is claimed as accepted.
    assign wr_ack = wr_en & ~w_full  & ~flush & reset_n;
    assign rd_ack = rd_en & ~w_empty & ~flush & reset_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr_ack) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (rd_ack) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    assign w_occupancy = r_wr_ptr - r_rd_ptr;
    assign occupancy   = w_occupancy;
    assign ptr_diff    = w_occupancy[A_LEN-1:0];
    assign wr_addr     = r_wr_ptr[A_LEN-1:0];
    assign rd_addr     = r_rd_ptr[A_LEN-1:0];
    assign MSB_wr_ptr  = r_wr_ptr[A_LEN];
    assign MSB_rd_ptr  = r_rd_ptr[A_LEN];

`ifdef FIFO_ERR_LOG_EN
    logic r_ovf_err;
    logic r_udf_err;

    // A new error event wins over a simultaneous clear; flush leaves the flags alone.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_err <= 1'b0;
            r_udf_err <= 1'b0;
        end else begin
            if (wr_en & w_full)       r_ovf_err <= 1'b1;
            else if (err_clr)         r_ovf_err <= 1'b0;
            if (rd_en & w_empty)      r_udf_err <= 1'b1;
            else if (err_clr)         r_udf_err <= 1'b0;
        end
    end

    assign ovf_err = r_ovf_err;
    assign udf_err = r_udf_err;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign ovf_err = 1'b0;
    assign udf_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_ptr_ctrl
// Brief    : Self-checking bench for fifo_ptr_ctrl against a count-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_ptr_ctrl;

    localparam int A_LEN = 3;
    localparam int DEPTH = 1 << A_LEN;
`ifdef FIFO_ERR_LOG_EN
    localparam int ERR_EN = 1;
`else
    localparam int ERR_EN = 0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             flush = 1'b0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic             err_clr = 1'b0;
    logic             wr_ack;
    logic             rd_ack;
    logic [A_LEN-1:0] wr_addr;
    logic [A_LEN-1:0] rd_addr;
    logic [A_LEN-1:0] ptr_diff;
    logic             MSB_wr_ptr;
    logic             MSB_rd_ptr;
    logic [A_LEN:0]   occupancy;
    logic             ovf_err;
    logic             udf_err;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_ptr_ctrl #(.A_LEN(A_LEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .err_clr    (err_clr),
        .wr_ack     (wr_ack),
        .rd_ack     (rd_ack),
        .wr_addr    (wr_addr),
        .rd_addr    (rd_addr),
        .ptr_diff   (ptr_diff),
        .MSB_wr_ptr (MSB_wr_ptr),
        .MSB_rd_ptr (MSB_rd_ptr),
        .occupancy  (occupancy),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    // Model: total accepted writes and reads since the last clear; everything
    // else follows from their difference and their values modulo the depth.
    int m_wr  = 0;
    int m_rd  = 0;
    int m_ovf = 0;
    int m_udf = 0;
    int e_occ;
    int e_full;
    int e_empty;
    int e_wr_ack;
    int e_rd_ack;

    always_comb begin
        e_occ    = m_wr - m_rd;
        e_full   = (e_occ == DEPTH) ? 1 : 0;
        e_empty  = (e_occ == 0) ? 1 : 0;
        e_wr_ack = (reset_n && wr_en && !flush && e_full == 0) ? 1 : 0;
        e_rd_ack = (reset_n && rd_en && !flush && e_empty == 0) ? 1 : 0;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_wr  <= 0;
            m_rd  <= 0;
            m_ovf <= 0;
            m_udf <= 0;
        end else begin
            if (flush) begin
                m_wr <= 0;
                m_rd <= 0;
            end else begin
                m_wr <= m_wr + e_wr_ack;
                m_rd <= m_rd + e_rd_ack;
            end
            if (ERR_EN != 0) begin
                if (wr_en && e_full != 0) m_ovf <= 1;
                else if (err_clr)         m_ovf <= 0;
                if (rd_en && e_empty != 0) m_udf <= 1;
                else if (err_clr)          m_udf <= 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("wr_ack",     int'(wr_ack),     e_wr_ack);
        chk("rd_ack",     int'(rd_ack),     e_rd_ack);
        chk("occupancy",  int'(occupancy),  e_occ);
        chk("ptr_diff",   int'(ptr_diff),   e_occ % DEPTH);
        chk("wr_addr",    int'(wr_addr),    m_wr % DEPTH);
        chk("rd_addr",    int'(rd_addr),    m_rd % DEPTH);
        chk("MSB_wr_ptr", int'(MSB_wr_ptr), (m_wr / DEPTH) % 2);
        chk("MSB_rd_ptr", int'(MSB_rd_ptr), (m_rd / DEPTH) % 2);
        chk("ovf_err",    int'(ovf_err),    m_ovf);
        chk("udf_err",    int'(udf_err),    m_udf);
    end

    task automatic step(input logic w, input logic r, input logic f, input logic c);
        wr_en = w; rd_en = r; flush = f; err_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("lit_reset_occ", int'(occupancy), 0);
        chk("lit_reset_ovf", int'(ovf_err), 0);

        // Fill to full
        repeat (8) step(1, 0, 0, 0);
        chk("lit_full_occ",   int'(occupancy), 8);
        chk("lit_full_diff",  int'(ptr_diff), 0);
        chk("lit_full_msbw",  int'(MSB_wr_ptr), 1);
        chk("lit_full_msbr",  int'(MSB_rd_ptr), 0);
        wr_en = 1; rd_en = 0;
        #1 chk("lit_9th_wr_ack", int'(wr_ack), 0);
        @(posedge clk); #1;
        chk("lit_9th_occ",  int'(occupancy), 8);
        chk("lit_9th_addr", int'(wr_addr), 0);

        // Both requests while full: only the read goes through
        wr_en = 1; rd_en = 1;
        #1 chk("lit_fullboth_rd", int'(rd_ack), 1);
        chk("lit_fullboth_wr", int'(wr_ack), 0);
        @(posedge clk); #1;
        chk("lit_fullboth_occ", int'(occupancy), 7);
        step(1, 0, 0, 0);

        // Drain to empty
        repeat (8) step(0, 1, 0, 0);
        chk("lit_empty_occ",  int'(occupancy), 0);
        chk("lit_empty_msbw", int'(MSB_wr_ptr), 1);
        chk("lit_empty_msbr", int'(MSB_rd_ptr), 1);
        wr_en = 0; rd_en = 1;
        #1 chk("lit_9th_rd_ack", int'(rd_ack), 0);
        @(posedge clk); #1;

        // Both requests while empty: only the write goes through
        wr_en = 1; rd_en = 1;
        #1 chk("lit_emptyboth_wr", int'(wr_ack), 1);
        chk("lit_emptyboth_rd", int'(rd_ack), 0);
        @(posedge clk); #1;
        chk("lit_emptyboth_occ", int'(occupancy), 1);
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0);
            chk("lit_stream_occ", int'(occupancy), 2);
        end

        // Asynchronous reset mid-cycle
        repeat (3) step(1, 0, 0, 0);
        chk("lit_pre_rst_occ", int'(occupancy), 5);
        wr_en = 0;
        reset_n = 0;
        #1 chk("lit_rst_occ", int'(occupancy), 0);
        chk("lit_rst_addr", int'(wr_addr), 0);
        chk("lit_rst_diff", int'(ptr_diff), 0);
        wr_en = 1;
        @(negedge clk);
        #2 reset_n = 1;
        @(posedge clk); #1;
        chk("lit_post_rst_occ", int'(occupancy), 1);

        // Flush beats a pending write
        repeat (4) step(1, 0, 0, 0);
        wr_en = 1; flush = 1;
        #1 chk("lit_flush_ack", int'(wr_ack), 0);
        @(posedge clk); #1;
        flush = 0; wr_en = 0;
        chk("lit_flush_occ", int'(occupancy), 0);
        chk("lit_flush_addr", int'(wr_addr), 0);

        // Sticky error flags
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("lit_udf", int'(udf_err), ERR_EN);
        repeat (8) step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lit_ovf", int'(ovf_err), ERR_EN);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit_ovf_clr", int'(ovf_err), 0);
        chk("lit_udf_clr", int'(udf_err), 0);

        // Randomized traffic with phases biased towards full and empty
        for (int i = 0; i < 3000; i++) begin
            int wp;
            wp = ((i / 150) % 2 == 0) ? 75 : 25;
            wr_en   = ($urandom_range(0, 99) < wp);
            rd_en   = ($urandom_range(0, 99) < (100 - wp));
            flush   = ($urandom_range(0, 59) == 0);
            err_clr = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #1 reset_n = 0;
                #1 reset_n = 1;
            end
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fifo_ptr_ctrl.md
Name: fifo_ptr_ctrl

Overview:
Read/write pointer controller for the synchronous FIFO. It sits directly upstream of the FIFO status-flag decoder and produces the low-order pointer difference and the pointer wrap bits that the decoder consumes. It also gates raw read/write requests against full and empty, and drives the RAM write and read addresses. Single clock domain.

Parameters:
A_LEN, 3, address width; FIFO depth = 2^A_LEN; must equal `a_length from para.h.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
reset_n  input  1  asynchronous, active-low reset; clears all state immediately.
flush  input  1  synchronous clear of both pointers; has priority over wr_en and rd_en.
wr_en  input  1  write request from producer.
rd_en  input  1  read request from consumer.
wr_ack  output  1  write accepted this cycle (combinational).
rd_ack  output  1  read accepted this cycle (combinational).
wr_addr  output  A_LEN  RAM write address = wr_ptr[A_LEN-1:0].
rd_addr  output  A_LEN  RAM read address = rd_ptr[A_LEN-1:0].
ptr_diff  output  A_LEN  (wr_ptr - rd_ptr) mod 2^A_LEN, fed to the flag decoder.
MSB_wr_ptr  output  1  wr_ptr[A_LEN] wrap bit.
MSB_rd_ptr  output  1  rd_ptr[A_LEN] wrap bit.
occupancy  output  A_LEN+1  (wr_ptr - rd_ptr) mod 2^(A_LEN+1); range 0..2^A_LEN.
ovf_err  output  1  sticky overflow flag (optional feature only; tied 0 otherwise).
udf_err  output  1  sticky underflow flag (optional feature only; tied 0 otherwise).
err_clr  input  1  synchronous clear of the sticky flags (optional feature only; ignored otherwise).

Behaviour:
- State: wr_ptr and rd_ptr registers, each A_LEN+1 bits and binary-coded. Both reset to 0.
- Internal full and empty, evaluated from the registered pointers:
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) and (MSBs differ).
- Handshake: wr_ack = wr_en & ~full & ~flush; rd_ack = rd_en & ~empty & ~flush.
- Pointer update on the rising clk edge:
  - wr_ptr += 1 when wr_ack; rd_ptr += 1 when rd_ack.
  - Increments wrap modulo 2^(A_LEN+1), so the MSB toggles every 2^A_LEN accesses.
- Outputs ptr_diff, MSBs, addresses and occupancy are combinational from the registers. Flags downstream therefore reflect an accepted access one cycle after the ack.
- Simultaneous wr_en and rd_en:
  - Not full and not empty: both accepted; occupancy unchanged; both pointers advance.
  - Full: read accepted, write rejected (no same-cycle pass-through). Next cycle occupancy = depth-1.
  - Empty: write accepted, read rejected. Next cycle occupancy = 1.
- flush=1: next edge sets both pointers to 0; acks are 0 that cycle.
- reset_n low at any time, including mid-burst: pointers go to 0 asynchronously and acks read 0 while reset is asserted. The first access after deassertion is accepted on the first clk edge with reset_n high.
- No other state. There is no FSM beyond the two counters and the optional error flags.

Optional Feature:
- FIFO_ERR_LOG_EN defined:
  - ovf_err sets on the edge where wr_en & full.
  - udf_err sets on the edge where rd_en & empty.
  - Both hold until err_clr or reset_n. Set has priority over err_clr in the same cycle.
  - flush does not clear them.
- Undefined: no flag registers; ovf_err = udf_err = 0; err_clr unused.

Test Plan:
- Reset then 8 writes (A_LEN=3) → wr_ack=1 for all 8; after the 8th edge wr_ptr=4'b1000, ptr_diff=0, MSB_wr_ptr=1, MSB_rd_ptr=0, occupancy=8. A 9th write gives wr_ack=0 and wr_ptr unchanged.
- Full, then 8 reads → rd_ack=1 ×8; afterwards rd_ptr=4'b1000, ptr_diff=0, both MSBs=1, occupancy=0. A 9th read gives rd_ack=0.
- Write 2, then hold wr_en=rd_en=1 for 20 cycles → occupancy stays 2 and ptr_diff=2 throughout; both MSBs toggle after 8 and 16 increments.
- Full with wr_en=rd_en=1 → rd_ack=1, wr_ack=0, next occupancy=7. Empty with both asserted → wr_ack=1, rd_ack=0, next occupancy=1.
- Write 5, assert reset_n=0 between edges → pointers, ptr_diff and occupancy read 0 before the next edge. Repeat with flush=1 → all 0 after one edge, acks 0 that cycle.
- FIFO_ERR_LOG_EN: wr_en at full → ovf_err=1 next edge and held; err_clr=1 → 0. rd_en at empty → udf_err=1. Without the macro both stay 0.
